taxi_eth_stat_accum: RTL and testbench
======================================

Name: taxi_eth_stat_accum

Overview:
- Sits directly downstream of the MAC statistics stream (m_axis_stat of the 1G MAC/FIFO wrapper) in the stat_clk domain.
- Each stream beat carries a counter index and an increment; the block accumulates increments into wide per-index counters held in block RAM.
- Host logic reads counters through a request/response port, with optional clear-on-read.

Parameters:
- STAT_INC_W, 16: increment width (s_axis_stat tdata width).
- STAT_ID_W, 8: counter index width (tid width); 2**STAT_ID_W counters.
- CNT_W, 48: accumulated counter width; must be >= STAT_INC_W.
- SATURATE_EN, 1'b0: 1 = saturate at all-ones, 0 = wrap modulo 2**CNT_W.
- CLEAR_ON_READ, 1'b0: 1 = counter zeroed atomically with a host read.

Ports:
- clk  in  1  stat clock
- rst  in  1  synchronous active-high reset
- s_axis_stat  taxi_axis_if.snk  -  tdata = increment, tid = counter index; tuser is ignored; no tkeep/tlast
- rd_req_valid  in  1  host read request
- rd_req_ready  out  1  read request accepted when valid & ready
- rd_req_id  in  STAT_ID_W  counter to read
- rd_resp_valid  out  1  single-cycle response strobe, no backpressure
- rd_resp_id  out  STAT_ID_W  echoed index
- rd_resp_data  out  CNT_W  counter value
- init_done  out  1  high once the RAM clear sweep completes

Behaviour:
- Reset: all outputs 0; s_axis_stat.tready = 0, rd_req_ready = 0, init_done = 0. Pipeline valids are cleared and any in-flight read response is dropped. Reset asserted mid-operation restarts the sweep.
- Init sweep:
  - INIT state writes 0 to index 0..2**STAT_ID_W-1, one per cycle.
  - Last write occurs in cycle 2**STAT_ID_W after rst deasserts; init_done is 1 the following cycle.
  - FSM then moves INIT -> RUN.
- RUN arbitration (one op per cycle):
  - When only one source is valid, it is granted.
  - When both are valid, grant alternates; the priority flag toggles on every contested grant, and its reset value is 1 = update first.
  - tready and rd_req_ready are combinational grants, never both 1 in the same cycle.
- Pipeline, with an op accepted in cycle t:
  - t: RAM read address = id.
  - t+1: RAM data valid (registered, read-first). Compute new value; write back at the end of t+1.
  - Update op: new = old + zero-extended inc. With SATURATE_EN, a carry out forces all-ones.
  - Read op: writes back old (or 0 if CLEAR_ON_READ). The t+1 value (pre-clear) is registered into rd_resp_*; rd_resp_valid = 1 in cycle t+2.
- Hazard bypass: if the stage-1 op in cycle t+1 has the same id as the stage-1 op in cycle t, use the registered write-back value instead of the RAM output. Back-to-back same-id updates must therefore never lose an increment.
- Throughput: 1 op/cycle sustained; no bubbles inserted for hazards.
- A zero increment is legal and writes back an unchanged value.

Decomposition:
- Shared package taxi_eth_stat_pkg:
  - op-type enum (OP_UPD, OP_RD);
  - FSM state enum (ST_INIT, ST_RUN);
  - stage-1 pipeline struct (valid, op, id, inc).
- One sub-module, taxi_eth_stat_ram: simple dual-port RAM, depth 2**STAT_ID_W, width CNT_W, 1-cycle registered read, read-first.

Test Plan:
- Init: deassert rst, read index 0 and index 255 after init_done -> init_done rises exactly 257 cycles after rst low; both reads return 0; tready low throughout the sweep.
- Accumulate: updates (id 3, 100), (id 3, 200), (id 3, 0xFFFF) on consecutive cycles, then read id 3 -> rd_resp_data = 65835, rd_resp_valid exactly 2 cycles after the read is accepted.
- Arbitration: hold tvalid and rd_req_valid high together for 8 cycles -> grants strictly alternate (update first, 4 each); no double grant in any cycle.
- Saturate/wrap (CNT_W = 16 build): two updates of 0xFFFF to id 7 -> read returns 0xFFFF with SATURATE_EN = 1, 0xFFFE with SATURATE_EN = 0.
- Clear-on-read (CLEAR_ON_READ = 1): update id 9 by 5, read id 9, update id 9 by 2 the very next cycle, read again -> first response 5, second response 2.
- Reset mid-op: assert rst one cycle after a read is accepted -> no rd_resp_valid pulse; init_done drops; after re-init all counters read 0.

Source files
------------

// File: rtl/taxi_eth_stat_pkg.sv
// taxi_eth_stat_pkg: shared op/state enums and the stage-1 pipeline record for the stat accumulator
package taxi_eth_stat_pkg;

    localparam int PKG_INC_W = 16;
    localparam int PKG_ID_W  = 8;

    typedef enum logic {
        OP_UPD = 1'b0,
        OP_RD  = 1'b1
    } op_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        op_e                  op;
        logic [PKG_ID_W-1:0]  id;
        logic [PKG_INC_W-1:0] inc;
    } stage_t;

endpackage

// File: rtl/taxi_axis_if.sv
// taxi_axis_if: minimal AXI-stream bundle (tdata, tid, tvalid, tready) with source/sink views
interface taxi_axis_if #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 8
);

    logic [DATA_W-1:0] tdata;
    logic [ID_W-1:0]   tid;
    logic              tvalid;
    logic              tready;

    modport src (output tdata, tid, tvalid, input tready);
    modport snk (input tdata, tid, tvalid, output tready);

endinterface

// File: rtl/taxi_eth_stat_ram.sv
// taxi_eth_stat_ram: simple dual-port counter RAM, registered read, read-first on address collision
//   clk              clock
//   wr_en/addr/data  write port, committed at the clock edge
//   rd_addr          read address, data appears on rd_data one cycle later (old contents on collision)
module taxi_eth_stat_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 48
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_data_q <= mem[rd_addr];
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/taxi_eth_stat_accum.sv
// taxi_eth_stat_accum: accumulates MAC statistic increments into wide per-index RAM counters with a host read port
//   clk, rst        stat clock, synchronous active-high reset
//   s_axis_stat     tdata = increment, tid = counter index
//   rd_req_*        host read request (valid/ready/id)
//   rd_resp_*       single-cycle read response strobe with echoed id and counter value
//   init_done       high once the RAM clear sweep has finished
module taxi_eth_stat_accum
    import taxi_eth_stat_pkg::*;
#(
    parameter int STAT_INC_W    = PKG_INC_W,
    parameter int STAT_ID_W     = PKG_ID_W,
    parameter int CNT_W         = 48,
    parameter bit SATURATE_EN   = 1'b0,
    parameter bit CLEAR_ON_READ = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    taxi_axis_if.snk             s_axis_stat,
    input  logic                 rd_req_valid,
    output logic                 rd_req_ready,
    input  logic [STAT_ID_W-1:0] rd_req_id,
    output logic                 rd_resp_valid,
    output logic [STAT_ID_W-1:0] rd_resp_id,
    output logic [CNT_W-1:0]     rd_resp_data,
    output logic                 init_done
);

    state_e               state_q, state_d;
    logic [STAT_ID_W-1:0] init_cnt_q, init_cnt_d;
    logic                 prio_q, prio_d;
    stage_t               s1_q, s1_d;
    logic [CNT_W-1:0]     wb_q, wb_d;
    logic [STAT_ID_W-1:0] wb_id_q, wb_id_d;
    logic                 wb_v_q, wb_v_d;
    logic                 resp_v_q, resp_v_d;
    logic [STAT_ID_W-1:0] resp_id_q, resp_id_d;
    logic [CNT_W-1:0]     resp_data_q, resp_data_d;

    logic                 run, g_upd, g_rd;
    logic [STAT_ID_W-1:0] ram_rd_addr, ram_wr_addr;
    logic                 ram_wr_en;
    logic [CNT_W-1:0]     ram_rd_data, ram_wr_data;
    logic [CNT_W-1:0]     old_val, upd_val, new_val;
    logic [CNT_W:0]       sum;

    always_comb begin
        run = state_q == ST_RUN;
        // prio_q = 1 favours the update stream when both sources contend
        g_upd = run && s_axis_stat.tvalid && (!rd_req_valid || prio_q);
        g_rd = run && rd_req_valid && (!s_axis_stat.tvalid || !prio_q);
        state_d = (!run && &init_cnt_q) ? ST_RUN : state_q;
        init_cnt_d = run ? init_cnt_q : init_cnt_q + 1'b1;
        prio_d = (run && s_axis_stat.tvalid && rd_req_valid) ? !prio_q : prio_q;
        ram_rd_addr = g_rd ? rd_req_id : s_axis_stat.tid;
        s1_d = '0;
        s1_d.valid = g_upd || g_rd;
        s1_d.op = g_rd ? OP_RD : OP_UPD;
        s1_d.id = ram_rd_addr;
        s1_d.inc = g_rd ? '0 : s_axis_stat.tdata;
        // the previous op's write-back has not reached the RAM read path yet
        old_val = (wb_v_q && wb_id_q == s1_q.id) ? wb_q : ram_rd_data;
        sum = {1'b0, old_val} + {{(CNT_W + 1 - STAT_INC_W){1'b0}}, s1_q.inc};
        upd_val = (SATURATE_EN && sum[CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        new_val = s1_q.op == OP_RD ? (CLEAR_ON_READ ? '0 : old_val) : upd_val;
        wb_d = new_val;
        wb_id_d = s1_q.id;
        wb_v_d = s1_q.valid;
        ram_wr_en = !run || s1_q.valid;
        ram_wr_addr = run ? s1_q.id : init_cnt_q;
        ram_wr_data = run ? new_val : '0;
        resp_v_d = s1_q.valid && s1_q.op == OP_RD;
        resp_id_d = s1_q.id;
        resp_data_d = old_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_INIT;
            init_cnt_q <= '0;
            prio_q <= 1'b1;
            s1_q <= '0;
            wb_q <= '0;
            wb_id_q <= '0;
            wb_v_q <= 1'b0;
            resp_v_q <= 1'b0;
            resp_id_q <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            init_cnt_q <= init_cnt_d;
            prio_q <= prio_d;
            s1_q <= s1_d;
            wb_q <= wb_d;
            wb_id_q <= wb_id_d;
            wb_v_q <= wb_v_d;
            resp_v_q <= resp_v_d;
            resp_id_q <= resp_id_d;
            resp_data_q <= resp_data_d;
        end
    end

    taxi_eth_stat_ram #(
        .ADDR_W(STAT_ID_W),
        .DATA_W(CNT_W)
    ) u_ram (
        .clk    (clk),
        .wr_en  (ram_wr_en),
        .wr_addr(ram_wr_addr),
        .wr_data(ram_wr_data),
        .rd_addr(ram_rd_addr),
        .rd_data(ram_rd_data)
    );

    assign s_axis_stat.tready = g_upd;
    assign rd_req_ready = g_rd;
    assign rd_resp_valid = resp_v_q;
    assign rd_resp_id = resp_id_q;
    assign rd_resp_data = resp_data_q;
    assign init_done = run;

endmodule

// File: tb/tb_taxi_eth_stat_accum.sv
// tb_taxi_eth_stat_accum: four builds (48b wrap, 16b saturate, 16b wrap, 48b clear-on-read) driven in lockstep
module tb_taxi_eth_stat_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tvalid = 1'b0;
    logic [7:0]  tid = '0;
    logic [15:0] tdata = '0;
    logic        rd_v = 1'b0;
    logic [7:0]  rd_id = '0;
    logic [3:0]  tr, rr, rv, idn;
    logic [7:0]  rid [4];
    logic [47:0] rd0, rd3;
    logic [15:0] rd1, rd2;
    logic [63:0] rdat [4];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    typedef struct packed {
        int              due;
        logic [7:0]      id;
        logic [3:0][63:0] d;
    } rec_t;

    typedef struct packed {
        logic        uv;
        logic [7:0]  uid;
        logic [15:0] uinc;
        logic        rv;
        logic [7:0]  rid;
        logic        etr;
        logic        err;
    } vec_t;

    rec_t            sb[$];
    vec_t            tbl[26];
    longint unsigned mcnt [4][256];

    taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax0 ();
    taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax1 ();
    taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax2 ();
    taxi_axis_if #(.DATA_W(16), .ID_W(8)) ax3 ();

    assign ax0.tdata = tdata;
    assign ax0.tid = tid;
    assign ax0.tvalid = tvalid;
    assign ax1.tdata = tdata;
    assign ax1.tid = tid;
    assign ax1.tvalid = tvalid;
    assign ax2.tdata = tdata;
    assign ax2.tid = tid;
    assign ax2.tvalid = tvalid;
    assign ax3.tdata = tdata;
    assign ax3.tid = tid;
    assign ax3.tvalid = tvalid;
    assign tr = {ax3.tready, ax2.tready, ax1.tready, ax0.tready};
    assign rdat[0] = {16'd0, rd0};
    assign rdat[1] = {48'd0, rd1};
    assign rdat[2] = {48'd0, rd2};
    assign rdat[3] = {16'd0, rd3};

    taxi_eth_stat_accum #(.CNT_W(48), .SATURATE_EN(1'b0), .CLEAR_ON_READ(1'b0)) u0 (
        .clk(clk), .rst(rst), .s_axis_stat(ax0), .rd_req_valid(rd_v), .rd_req_ready(rr[0]), .rd_req_id(rd_id),
        .rd_resp_valid(rv[0]), .rd_resp_id(rid[0]), .rd_resp_data(rd0), .init_done(idn[0]));
    taxi_eth_stat_accum #(.CNT_W(16), .SATURATE_EN(1'b1), .CLEAR_ON_READ(1'b0)) u1 (
        .clk(clk), .rst(rst), .s_axis_stat(ax1), .rd_req_valid(rd_v), .rd_req_ready(rr[1]), .rd_req_id(rd_id),
        .rd_resp_valid(rv[1]), .rd_resp_id(rid[1]), .rd_resp_data(rd1), .init_done(idn[1]));
    taxi_eth_stat_accum #(.CNT_W(16), .SATURATE_EN(1'b0), .CLEAR_ON_READ(1'b0)) u2 (
        .clk(clk), .rst(rst), .s_axis_stat(ax2), .rd_req_valid(rd_v), .rd_req_ready(rr[2]), .rd_req_id(rd_id),
        .rd_resp_valid(rv[2]), .rd_resp_id(rid[2]), .rd_resp_data(rd2), .init_done(idn[2]));
    taxi_eth_stat_accum #(.CNT_W(48), .SATURATE_EN(1'b0), .CLEAR_ON_READ(1'b1)) u3 (
        .clk(clk), .rst(rst), .s_axis_stat(ax3), .rd_req_valid(rd_v), .rd_req_ready(rr[3]), .rd_req_id(rd_id),
        .rd_resp_valid(rv[3]), .rd_resp_id(rid[3]), .rd_resp_data(rd3), .init_done(idn[3]));

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic uv, input logic [7:0] uid, input logic [15:0] uinc,
                                input logic rvl, input logic [7:0] ridv, input logic etr, input logic err);
        vec_t v;
        v.uv = uv;
        v.uid = uid;
        v.uinc = uinc;
        v.rv = rvl;
        v.rid = ridv;
        v.etr = etr;
        v.err = err;
        return v;
    endfunction

    // Reference counters: 0 = 48b wrap, 1 = 16b saturate, 2 = 16b wrap, 3 = 48b clear-on-read
    task automatic m_upd(input logic [7:0] id, input logic [15:0] inc);
        for (int k = 0; k < 4; k++) begin
            longint unsigned lim = (k == 1 || k == 2) ? 64'hFFFF : 64'hFFFF_FFFF_FFFF;
            longint unsigned s = mcnt[k][id] + 64'(inc);
            mcnt[k][id] = (s > lim) ? ((k == 1) ? lim : (s & lim)) : s;
        end
    endtask

    task automatic m_rd(input logic [7:0] id);
        rec_t r;
        r.due = cyc + 2;
        r.id = id;
        for (int k = 0; k < 4; k++) begin
            r.d[k] = mcnt[k][id];
            if (k == 3) mcnt[k][id] = 0;
        end
        sb.push_back(r);
    endtask

    task automatic m_clear();
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 256; i++)
                mcnt[k][i] = 0;
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        tvalid = v.uv;
        tid = v.uid;
        tdata = v.uinc;
        rd_v = v.rv;
        rd_id = v.rid;
        #1;
        chk("tready", tr, {4{v.etr}});
        chk("rd_req_ready", rr, {4{v.err}});
        chk("single grant", tr & rr, 0);
        if (v.etr) m_upd(v.uid, v.uinc);
        if (v.err) m_rd(v.rid);
    endtask

    task automatic wait_init(output int n);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            #1;
            if (idn[0]) break;
        end
    endtask

    always @(posedge clk) begin
        #3;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (!rv[k] || rid[k] != sb[0].id || rdat[k] != sb[0].d[k]) begin
                    n_err++;
                    $display("FAIL resp inst%0d: valid %0b id %0d data 0x%0h, expected id %0d data 0x%0h (cycle %0d)",
                             k, rv[k], rid[k], rdat[k], sb[0].id, sb[0].d[k], cyc);
                end
            end
            void'(sb.pop_front());
        end else if (rv != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected resp: rd_resp_valid %b, expected 0000 (cycle %0d)", rv, cyc);
        end
    end

    initial begin
        int n;
        int bad;
        tbl[0] = mk(0, 0, 0, 1, 0, 0, 1);
        tbl[1] = mk(0, 0, 0, 1, 255, 0, 1);
        tbl[2] = mk(1, 3, 100, 0, 0, 1, 0);
        tbl[3] = mk(1, 3, 200, 0, 0, 1, 0);
        tbl[4] = mk(1, 3, 16'hFFFF, 0, 0, 1, 0);
        tbl[5] = mk(0, 0, 0, 1, 3, 0, 1);
        for (int i = 6; i < 14; i++) tbl[i] = mk(1, 4, 10, 1, 4, i[0] == 1'b0, i[0] == 1'b1);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 0);
        tbl[15] = mk(1, 7, 16'hFFFF, 0, 0, 1, 0);
        tbl[16] = mk(1, 7, 16'hFFFF, 0, 0, 1, 0);
        tbl[17] = mk(0, 0, 0, 1, 7, 0, 1);
        tbl[18] = mk(1, 9, 5, 0, 0, 1, 0);
        tbl[19] = mk(0, 0, 0, 1, 9, 0, 1);
        tbl[20] = mk(1, 9, 2, 0, 0, 1, 0);
        tbl[21] = mk(0, 0, 0, 1, 9, 0, 1);
        tbl[22] = mk(1, 3, 0, 0, 0, 1, 0);
        tbl[23] = mk(0, 0, 0, 1, 3, 0, 1);
        tbl[24] = mk(1, 10, 1, 1, 10, 1, 0);
        tbl[25] = mk(1, 10, 1, 1, 10, 0, 1);

        tvalid = 1'b1;
        rd_v = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("reset tready", tr, 0);
        chk("reset rd_req_ready", rr, 0);
        chk("reset rd_resp_valid", rv, 0);
        chk("reset init_done", idn, 0);
        chk("reset rd_resp_data", rdat[0], 0);

        rst = 1'b0;
        n = 1;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            n++;
            #1;
            if (idn[0]) break;
            if (tr != 0 || rr != 0) bad++;
        end
        tvalid = 1'b0;
        rd_v = 1'b0;
        chk("init_done cycle", n, 257);
        chk("grants during sweep", bad, 0);
        chk("init_done all builds", idn, 4'hF);

        for (int i = 0; i < 26; i++) drive(tbl[i]);
        repeat (4) drive(mk(0, 0, 0, 0, 0, 0, 0));
        chk("scoreboard drained", sb.size(), 0);

        drive(mk(0, 0, 0, 1, 3, 0, 1));
        @(negedge clk);
        rst = 1'b1;
        rd_v = 1'b0;
        sb.delete();
        @(posedge clk);
        #3;
        chk("mid-op reset rd_resp_valid", rv, 0);
        chk("mid-op reset init_done", idn, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_init(n);
        chk("re-init cycle", n, 257);
        m_clear();
        drive(mk(0, 0, 0, 1, 3, 0, 1));
        drive(mk(0, 0, 0, 1, 7, 0, 1));
        drive(mk(0, 0, 0, 1, 9, 0, 1));
        drive(mk(0, 0, 0, 1, 4, 0, 1));
        repeat (4) drive(mk(0, 0, 0, 0, 0, 0, 0));
        chk("scoreboard drained after re-init", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
